// File: rtl/cdb_arbiter.sv
// cdb_arbiter: N_REQ holding slots, one registered CDB broadcast per cycle.
// Round-robin grant by default. Define CDB_FIXED_PRIO_EN for a lowest-index-wins grant with no rr_ptr.
// Ports: clk, rst (async, active-low), rdy (global enable), Clear_flag (flush),
//        req_valid/req_tag/req_value in, req_ready out, cdb_valid/tag/value/src out.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      Clear_flag,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_value,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [1:0]                cdb_src
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  full_q, full_d;
  logic [TAG_W-1:0]  tag_q [N_REQ];
  logic [TAG_W-1:0]  tag_d [N_REQ];
  logic [DATA_W-1:0] val_q [N_REQ];
  logic [DATA_W-1:0] val_d [N_REQ];

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [1:0]        cdb_src_q, cdb_src_d;

  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  xfer;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [TAG_W-1:0]  gnt_tag;
  logic [DATA_W-1:0] gnt_val;

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && full_q[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
        gnt[k]  = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Search upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_any && full_q[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
        gnt[j]  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (Clear_flag) begin
      rr_ptr_d = '0;
    end else if (gnt_any) begin
      if (gnt_idx == PW'(N_REQ - 1)) rr_ptr_d = '0;
      else                           rr_ptr_d = gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rr_ptr_q <= '0;
    else if (rdy) rr_ptr_q <= rr_ptr_d;
  end
`endif

  // A granted slot is draining this edge, so it can accept again.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (!full_q[i] || gnt[i]) && rdy && !Clear_flag && rst;
    end
  end

  assign xfer = req_valid & req_ready;

  // One-hot grant lets an OR-reduce act as the mux.
  always_comb begin
    gnt_tag = '0;
    gnt_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_tag = gnt_tag | tag_q[i];
        gnt_val = gnt_val | val_q[i];
      end
    end
  end

  always_comb begin
    full_d = full_q;
    for (int i = 0; i < N_REQ; i++) begin
      tag_d[i] = tag_q[i];
      val_d[i] = val_q[i];
    end
    if (Clear_flag) begin
      full_d = '0;
    end else begin
      // A refill of the granted slot wins over its clear.
      full_d = (full_q & ~gnt) | xfer;
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer[i]) begin
          tag_d[i] = req_tag[i*TAG_W +: TAG_W];
          val_d[i] = req_value[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    if (!Clear_flag && gnt_any) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = gnt_tag;
      cdb_value_d = gnt_val;
      cdb_src_d   = 2'(gnt_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else if (rdy) begin
      full_q <= full_d;
      for (int i = 0; i < N_REQ; i++) begin
        tag_q[i] <= tag_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else if (rdy) begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus, reference model, literal pins.
// Model tracks slots, pointer and expected broadcast from the arbitration rules.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            clr;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [1:0]      cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .Clear_flag(clr),
    .req_valid(req_valid),
    .req_tag(req_tag),
    .req_value(req_value),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .cdb_src(cdb_src)
  );

  int errs   = 0;
  int checks = 0;

  bit          m_full [N];
  logic [3:0]  m_tag  [N];
  logic [31:0] m_val  [N];
  int          m_ptr;
  bit          m_cv;
  logic [3:0]  m_ct;
  logic [31:0] m_cd;
  int          m_cs;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0;
      m_tag[i]  = '0;
      m_val[i]  = '0;
    end
    m_ptr = 0;
    m_cv  = 0;
    m_ct  = '0;
    m_cd  = '0;
    m_cs  = 0;
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int j;
`ifdef CDB_FIXED_PRIO_EN
      j = k;
`else
      j = (m_ptr + k) % N;
`endif
      if (m_full[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    int g;
    g = m_grant();
    return (!m_full[i] || g == i) && rdy && !clr && rst;
  endfunction

  task automatic set_req(int i, bit v, logic [3:0] t, logic [31:0] d);
    req_valid[i]        = v;
    req_tag[i*TW +: TW] = t;
    req_value[i*DW +: DW] = d;
  endtask

  task automatic idle_reqs();
    req_valid = '0;
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick();
    int g;
    bit rd [N];
    #1;
    g = m_grant();
    for (int i = 0; i < N; i++) begin
      rd[i] = m_ready(i);
      chk($sformatf("ready%0d", i), req_ready[i], rd[i]);
    end
    if (rdy) begin
      if (clr) begin
        for (int i = 0; i < N; i++) m_full[i] = 0;
        m_cv  = 0;
        m_ptr = 0;
      end else begin
        if (g >= 0) begin
          m_cv = 1;
          m_ct = m_tag[g];
          m_cd = m_val[g];
          m_cs = g;
          m_full[g] = 0;
          m_ptr = (g + 1) % N;
        end else begin
          m_cv = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && rd[i]) begin
            m_full[i] = 1;
            m_tag[i]  = req_tag[i*TW +: TW];
            m_val[i]  = req_value[i*DW +: DW];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", cdb_valid, m_cv);
    chk("cdb_tag", cdb_tag, m_ct);
    chk("cdb_value", cdb_value, m_cd);
    chk("cdb_src", cdb_src, m_cs);
    @(negedge clk);
  endtask

  // Asynchronous: asserted at a negedge and observed before any posedge.
  task automatic reset_dut();
    rst = 1'b0;
    #1;
    chk("rst_valid", cdb_valid, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_value", cdb_value, 0);
    chk("rst_src", cdb_src, 0);
    chk("rst_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    clr = 1'b0;
    req_valid = '1;
    req_tag   = '1;
    req_value = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_valid", cdb_valid, 0);
    chk("por_tag", cdb_tag, 0);
    chk("por_value", cdb_value, 0);
    chk("por_src", cdb_src, 0);
    chk("por_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    idle_reqs();

    // single request, one-cycle latency
    set_req(0, 1, 4'd3, 32'h11);
    #1;
    chk("s1_ready_empty", req_ready[0], 1);
    tick();
    chk("s1_no_valid_yet", cdb_valid, 0);
    idle_reqs();
    #1;
    chk("s1_ready_full", req_ready[0], 1);
    tick();
    chk("s1_valid", cdb_valid, 1);
    chk("s1_tag", cdb_tag, 3);
    chk("s1_value", cdb_value, 32'h11);
    chk("s1_src", cdb_src, 0);
    tick();

    // three simultaneous requests drain in order 0,1,2 then wrap
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 1, 4'(i + 1), 32'h100 + i);
    tick();
    idle_reqs();
    for (int k = 0; k < N; k++) begin
      tick();
      chk($sformatf("rr_src%0d", k), cdb_src, k);
      chk($sformatf("rr_tag%0d", k), cdb_tag, k + 1);
    end
    set_req(1, 1, 4'd7, 32'h71);
    set_req(0, 1, 4'd6, 32'h61);
    tick();
    idle_reqs();
    tick();
    chk("wrap_src", cdb_src, 0);
    chk("wrap_tag", cdb_tag, 6);
    tick();
    chk("wrap_src2", cdb_src, 1);
    tick();
    chk("drain_idle", cdb_valid, 0);

    // back-to-back stream from requester 1
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      set_req(1, 1, 4'(4 + k), 32'h200 + k);
      tick();
      if (k > 0) begin
        chk($sformatf("b2b_valid%0d", k), cdb_valid, 1);
        chk($sformatf("b2b_tag%0d", k), cdb_tag, 4 + k - 1);
      end
    end
    idle_reqs();
    tick();
    chk("b2b_last", cdb_tag, 9);
    chk("b2b_last_v", cdb_valid, 1);
    tick();
    chk("b2b_done", cdb_valid, 0);

    // flush with slots 0 and 2 full
    set_req(0, 1, 4'hA, 32'hA0);
    set_req(2, 1, 4'hC, 32'hC0);
    tick();
    idle_reqs();
    set_req(1, 1, 4'hB, 32'hB0);
    clr = 1'b1;
    #1;
    chk("flush_ready", req_ready, 0);
    tick();
    clr = 1'b0;
    idle_reqs();
    chk("flush_valid", cdb_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush_quiet%0d", k), cdb_valid, 0);
    end

    // rdy low freezes a full slot
    set_req(1, 1, 4'd5, 32'h55);
    tick();
    idle_reqs();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("frz_valid%0d", k), cdb_valid, 0);
      chk($sformatf("frz_ready%0d", k), req_ready, 0);
    end
    rdy = 1'b1;
    tick();
    chk("thaw_valid", cdb_valid, 1);
    chk("thaw_tag", cdb_tag, 5);
    chk("thaw_value", cdb_value, 32'h55);
    chk("thaw_src", cdb_src, 1);
    tick();

    // requesters 0 and 2 always valid
    reset_dut();
    set_req(0, 1, 4'hA, 32'hAA);
    set_req(2, 1, 4'hC, 32'hCC);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t >= 2) begin
        chk($sformatf("cont_v%0d", t), cdb_valid, 1);
`ifdef CDB_FIXED_PRIO_EN
        chk($sformatf("cont_src%0d", t), cdb_src, 0);
`else
        chk($sformatf("cont_src%0d", t), cdb_src, (t % 2 == 0) ? 0 : 2);
`endif
      end
    end
    idle_reqs();
    repeat (3) tick();

    // reset mid-operation discards held results
    for (int i = 0; i < N; i++) set_req(i, 1, 4'(8 + i), 32'h800 + i);
    tick();
    idle_reqs();
    reset_dut();
    tick();
    chk("post_rst_valid", cdb_valid, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of result producers (0 = RS/ALU, 1 = SLB load, 2 = spare).
REQ-002 Parameter TAG_W, default 4, width of the ROB-index tag.
REQ-003 Parameter DATA_W, default 32, result value width.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port rdy  input  1  global enable; low freezes all state.
REQ-007 Port Clear_flag  input  1  misprediction flush.
REQ-008 Port req_valid  input  N_REQ  per-requester result valid.
REQ-009 Port req_tag  input  N_REQ*TAG_W  per-requester ROB tag; requester i occupies bits [i*TAG_W +: TAG_W].
REQ-010 Port req_value  input  N_REQ*DATA_W  per-requester result; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port req_ready  output  N_REQ  per-requester accept.
REQ-012 Port cdb_valid  output  1  broadcast valid, registered.
REQ-013 Port cdb_tag  output  TAG_W  broadcast ROB tag, registered.
REQ-014 Port cdb_value  output  DATA_W  broadcast value, registered.
REQ-015 Port cdb_src  output  2  index of the granted requester, registered.

Function
REQ-016 Each requester SHALL own one holding slot (full bit, tag, value).
REQ-017 A transfer SHALL occur on an edge where req_valid[i] and req_ready[i] are both 1, rdy is 1 and Clear_flag is 0; slot i becomes full after that edge.
REQ-018 req_ready[i] SHALL be (!full[i] || grant[i]) && rdy && !Clear_flag, computed combinationally.
REQ-019 Each cycle, at most one full slot SHALL be granted; grant SHALL be combinational from the full bits and rr_ptr.
REQ-020 Round-robin mode: the first full slot found searching upward from rr_ptr, wrapping N_REQ-1 to 0, SHALL be granted.
REQ-021 After granting i, rr_ptr SHALL become (i+1) mod N_REQ; with no grant, rr_ptr SHALL be unchanged.
REQ-022 On an edge with a grant, cdb_valid SHALL be 1 and cdb_tag, cdb_value and cdb_src SHALL take the granted slot's contents.
REQ-023 On an edge with no grant, cdb_valid SHALL be 0 and cdb_tag, cdb_value and cdb_src SHALL hold their values.
REQ-024 The granted slot SHALL clear unless a new transfer into the same slot occurs on the same edge; in that case the slot SHALL hold the new data.
REQ-025 Latency SHALL be one cycle: a transfer at edge N with an empty arbiter gives cdb_valid high after edge N+1.
REQ-026 Sustained throughput SHALL be one broadcast per cycle while any slot is full.
REQ-027 On an edge with Clear_flag=1 and rdy=1, all full bits SHALL clear, cdb_valid SHALL go to 0 and rr_ptr SHALL go to 0.
REQ-028 Clear_flag SHALL take precedence over any concurrent transfer or grant.
REQ-029 With rdy=0, no state SHALL change, including the cdb_* outputs.

Reset
REQ-030 While rst=0, regardless of clk, all full bits SHALL be 0, rr_ptr 0, cdb_valid 0, cdb_tag 0, cdb_value 0 and cdb_src 0.
REQ-031 Reset asserted mid-operation SHALL discard all held results.
REQ-032 req_ready SHALL be 0 while rst=0.

Configuration
REQ-033 Macro CDB_FIXED_PRIO_EN: when defined, grant SHALL go to the lowest-index full slot and rr_ptr SHALL be absent; when undefined, round-robin per REQ-020/021 SHALL apply.

Verification
REQ-034 Reset, then requester 0 presents tag=3, value=0x11 at cycle 1 -> cdb_valid=1, tag=3, value=0x11, src=0 after the following edge; req_ready[0] stays 1.
REQ-035 Requesters 0, 1 and 2 all present in the same cycle (tags 1, 2, 3) -> broadcasts in three consecutive cycles with src 0, 1, 2; rr_ptr wraps to 0.
REQ-036 Requester 1 holds req_valid for 6 cycles (tags 4..9) while requester 0 is idle -> six back-to-back broadcasts, no bubble.
REQ-037 Slots 0 and 2 full and Clear_flag pulsed -> next cycle cdb_valid=0; no later broadcast of the held tags; req_ready=0 during the flush cycle.
REQ-038 rdy held low 3 cycles with slot 1 full -> cdb outputs and slot frozen; broadcast occurs one edge after rdy rises.
REQ-039 Build with CDB_FIXED_PRIO_EN and keep requesters 0 and 2 constantly valid -> src always 0; requester 2 starves.
